contador_periodos_multicanal: RTL and testbench
===============================================

# contador_periodos_multicanal

Parametrised multi-channel period meter. It measures the time between two consecutive selected edges on each of `NUM_CANAIS` independent asynchronous inputs and reports the result in whole ticks of `CICLOS_POR_TICK` clock cycles. It adds several things a single-channel single-shot counter lacks: input synchronisation, per-channel edge selection, a continuous (back-to-back) mode, timeout, saturation, and an abort control. It sits between raw sensor/pulse inputs and the register/telemetry logic.

## Interface
- `NUM_CANAIS`, 4: number of independent channels (1..16).
- `CICLOS_POR_TICK`, 1000: clock cycles per result tick (≥2).
- `LARGURA`, 32: width of each period result and tick counter.
- `TIMEOUT_TICKS`, 0: tick count that aborts a measurement; 0 disables the timeout.
- `clk  in  1`: single clock; all logic is on the rising edge.
- `rst_n  in  1`: reset, asynchronous and active-low.
- `sinal_in  in  NUM_CANAIS`: asynchronous inputs, one bit per channel.
- `borda_descida  in  NUM_CANAIS`: per-channel edge select; 0 = rising, 1 = falling. Sampled continuously; change it only while the channel is IDLE.
- `modo_continuo  in  1`: 0 = single-shot; 1 = continuous. Latched per channel on start.
- `start  in  1`: one-cycle request; arms every channel that is set in `canal_mask` and is IDLE.
- `canal_mask  in  NUM_CANAIS`: channels addressed by `start`.
- `stop  in  1`: aborts all channels.
- `ready  out  1`: high when every channel is IDLE.
- `done  out  NUM_CANAIS`: one-cycle pulse per channel when a new result is written.
- `timeout  out  NUM_CANAIS`: one-cycle pulse per channel when a measurement is aborted by timeout.
- `valido  out  NUM_CANAIS`: sticky flag, set by the channel's first result.
- `periodo  out  NUM_CANAIS*LARGURA`: channel i's result occupies bits [i*LARGURA +: LARGURA].

## Operation
- **Input conditioning.** Each channel passes through a 2-flop synchroniser plus one history flop. The channel's edge pulse `ev` is high for one cycle when the synchronised value changes in the selected direction.
- **Per-channel FSM: IDLE → ARMADO → CONTANDO.**
  - IDLE: `start` with the channel's mask bit set moves to ARMADO and latches `modo_continuo`. All other inputs are ignored.
  - ARMADO: `ev` moves to CONTANDO and clears the cycle and tick counters. No timeout applies in ARMADO.
  - CONTANDO, counting: every cycle the cycle counter increments. When it reaches `CICLOS_POR_TICK-1` it wraps to 0 and the tick counter increments. The tick counter saturates at 2^LARGURA−1 and never wraps.
  - CONTANDO, on `ev`: the updated tick count (including any increment made this cycle) is written to `periodo[i]`, and `done[i]` and `valido[i]` are set. Single-shot mode then goes to IDLE. Continuous mode stays in CONTANDO with both counters cleared, so the closing edge is also the next opening edge and there is no dead time.
  - CONTANDO, timeout: when `TIMEOUT_TICKS≠0` and the tick counter reaches `TIMEOUT_TICKS`, the channel pulses `timeout[i]` and leaves `periodo`/`valido` unchanged. Single-shot mode goes to IDLE; continuous mode goes to ARMADO.
- **Result value.** `periodo = floor(D / CICLOS_POR_TICK)`, where D is the distance in cycles between the two `ev` pulses, saturated.
- **Priority, highest first:** `rst_n`, `stop`, `ev`, timeout.
  - `stop` forces every channel to IDLE on the next edge, with no `done` or `timeout`. Results are kept.
  - When `ev` and timeout fall in the same cycle, the result is written and no timeout pulse is produced.
- **`start` corner cases.** `start` with mask 0, or aimed at busy channels, has no effect on those channels. `start` and `stop` in the same cycle: `stop` wins.
- **Reset.** `rst_n` low at any time, including mid-measurement, immediately puts every channel in IDLE, clears all counters, `periodo`, `valido`, `done` and `timeout`, and makes `ready` = 1.

## Timing
- An input transition appears as `ev` 3 cycles later.
- `done`, `timeout` and the `periodo` update are registered; all become visible the cycle after the triggering `ev` or tick.
- `ready` is combinational from channel states. It falls the cycle after an accepted `start` and rises the cycle after the last channel returns to IDLE.
- Minimum measurable D: 1 cycle (result 0). Continuous mode accepts an edge every cycle.
- Reset values of all outputs: `ready`=1; `done`, `timeout`, `valido`, `periodo` = 0.

## Structure
- Package `contador_periodos_pkg`: enum `estado_canal_t` {IDLE, ARMADO, CONTANDO} and localparam helpers (counter width `$clog2(CICLOS_POR_TICK)`).
- Sub-module `canal_periodo`: one channel, holding the synchroniser, edge detect, FSM, both counters and the result register. Instantiate it in a generate loop.
- The top level contains only the `ready` reduction and the bus packing.

## Test plan
All scenarios use `CICLOS_POR_TICK`=10, `LARGURA`=16.
- **Single-shot, rising.** Ch0 `start`, rising edges 250 cycles apart → one `done[0]`, `periodo[0]`=25, `valido[0]`=1, then `ready`=1.
- **Falling edge, D=109.** Ch1 `borda_descida`=1, falling edges 109 cycles apart, rising edges ignored → `periodo[1]`=10.
- **Continuous, four channels.** Ch0..3 continuous, periods 100, 200, 300 on ch2 → `done[2]` pulses with 10, 20, 30, no gaps; other channels remain independent.
- **Timeout and ev/timeout collision.** `TIMEOUT_TICKS`=50, no second edge → `timeout[0]` 500 cycles after the opening `ev`, `periodo` unchanged. Repeat with the edge landing exactly on tick 50 → `done` with 50, no `timeout`.
- **Saturation.** `LARGURA`=4, D=300 → `periodo`=15.
- **Stop and reset mid-count.** `stop` while ch0 is counting → IDLE, no `done`, old result kept. `rst_n` low mid-count → all outputs zero immediately, `ready`=1.

Source files
------------

// File: rtl/contador_periodos_pkg.sv
// contador_periodos_pkg: shared channel state type and sizing helper for the period meter
package contador_periodos_pkg;

  typedef enum logic [1:0] {IDLE, ARMADO, CONTANDO} estado_canal_t;

  // Width of the sub-tick cycle counter; CICLOS_POR_TICK is at least 2 so this is never 0
  function automatic int largura_ciclos(input int ciclos_por_tick);
    return $clog2(ciclos_por_tick);
  endfunction

endpackage

// File: rtl/canal_periodo.sv
// canal_periodo: one period-meter channel (synchroniser, edge detect, FSM, counters, result)
module canal_periodo
  import contador_periodos_pkg::*;
#(
  parameter int CICLOS_POR_TICK = 1000,
  parameter int LARGURA         = 32,
  parameter int TIMEOUT_TICKS   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sinal_in,
  input  logic               borda_descida,
  input  logic               modo_continuo,
  input  logic               start,
  input  logic               stop,
  output logic               ocioso,
  output logic               done,
  output logic               timeout,
  output logic               valido,
  output logic [LARGURA-1:0] periodo
);

  localparam int                 CW     = largura_ciclos(CICLOS_POR_TICK);
  localparam logic [CW-1:0]      ULTIMO = CW'(CICLOS_POR_TICK - 1);
  localparam logic [LARGURA-1:0] LIMITE = LARGURA'(TIMEOUT_TICKS);
  localparam logic [LARGURA-1:0] MAXIMO = '1;

  estado_canal_t      estado, proximo;
  logic [2:0]         sinc;
  logic               continuo, ev, wrap, expira, fecha, aborta;
  logic [CW-1:0]      ciclos, ciclos_n;
  logic [LARGURA-1:0] ticks, ticks_n;

  // sinc[1:0] is the two-flop synchroniser, sinc[2] the history flop for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sinc <= '0;
    else sinc <= {sinc[1:0], sinal_in};

  assign ev       = borda_descida ? (~sinc[1] & sinc[2]) : (sinc[1] & ~sinc[2]);
  assign wrap     = ciclos == ULTIMO;
  assign ciclos_n = wrap ? '0 : ciclos + 1'b1;
  assign ticks_n  = (wrap && ticks != MAXIMO) ? ticks + 1'b1 : ticks;
  assign expira   = (TIMEOUT_TICKS != 0) && wrap && (ticks_n == LIMITE);

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) estado <= IDLE;
    else estado <= proximo;

  // Next state: stop beats everything, a closing edge beats a coincident timeout
  always_comb
    proximo = stop                            ? IDLE :
              (estado == IDLE && start)       ? ARMADO :
              (estado == ARMADO && ev)        ? CONTANDO :
              (estado == CONTANDO && ev)      ? (continuo ? CONTANDO : IDLE) :
              (estado == CONTANDO && expira)  ? (continuo ? ARMADO : IDLE) :
              estado;

  // Decoded events that drive the registered outputs
  always_comb begin
    ocioso = estado == IDLE;
    fecha  = !stop && estado == CONTANDO && ev;
    aborta = !stop && estado == CONTANDO && !ev && expira;
  end

  // Counters, mode latch, result register and one-cycle pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      continuo <= 1'b0;
      ciclos   <= '0;
      ticks    <= '0;
      periodo  <= '0;
      valido   <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      done    <= fecha;
      timeout <= aborta;
      if (estado == IDLE && start && !stop) continuo <= modo_continuo;
      if ((estado == ARMADO && ev) || fecha) begin
        ciclos <= '0;
        ticks  <= '0;
      end else if (estado == CONTANDO) begin
        ciclos <= ciclos_n;
        ticks  <= ticks_n;
      end
      if (fecha) begin
        periodo <= ticks_n;
        valido  <= 1'b1;
      end
    end

endmodule

// File: rtl/contador_periodos_multicanal.sv
// contador_periodos_multicanal: multi-channel period meter, per-channel instances plus ready and bus packing
module contador_periodos_multicanal #(
  parameter int NUM_CANAIS      = 4,
  parameter int CICLOS_POR_TICK = 1000,
  parameter int LARGURA         = 32,
  parameter int TIMEOUT_TICKS   = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CANAIS-1:0]         sinal_in,
  input  logic [NUM_CANAIS-1:0]         borda_descida,
  input  logic                          modo_continuo,
  input  logic                          start,
  input  logic [NUM_CANAIS-1:0]         canal_mask,
  input  logic                          stop,
  output logic                          ready,
  output logic [NUM_CANAIS-1:0]         done,
  output logic [NUM_CANAIS-1:0]         timeout,
  output logic [NUM_CANAIS-1:0]         valido,
  output logic [NUM_CANAIS*LARGURA-1:0] periodo
);

  logic [NUM_CANAIS-1:0] ocioso;

  genvar i;
  generate
    for (i = 0; i < NUM_CANAIS; i++) begin : g_canal
      canal_periodo #(
        .CICLOS_POR_TICK(CICLOS_POR_TICK),
        .LARGURA        (LARGURA),
        .TIMEOUT_TICKS  (TIMEOUT_TICKS)
      ) u_canal (
        .clk          (clk),
        .rst_n        (rst_n),
        .sinal_in     (sinal_in[i]),
        .borda_descida(borda_descida[i]),
        .modo_continuo(modo_continuo),
        .start        (start & canal_mask[i]),
        .stop         (stop),
        .ocioso       (ocioso[i]),
        .done         (done[i]),
        .timeout      (timeout[i]),
        .valido       (valido[i]),
        .periodo      (periodo[i*LARGURA +: LARGURA])
      );
    end
  endgenerate

  assign ready = &ocioso;

endmodule

// File: tb/tb_contador_periodos_multicanal.sv
// tb_contador_periodos_multicanal: directed self-checking bench for the multi-channel period meter
module tb_contador_periodos_multicanal;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sinal_in, borda_descida, canal_mask;
  logic        modo_continuo, start, stop;
  logic        ready;
  logic [3:0]  done, timeout, valido;
  logic [63:0] periodo;
  logic        s_ready;
  logic [0:0]  s_done, s_timeout, s_valido;
  logic [3:0]  s_periodo;

  int tests = 0, failed = 0, cyc = 0;
  int done_cnt[4] = '{0, 0, 0, 0};
  int to_cnt[4] = '{0, 0, 0, 0};
  int to_t = 0, sd_cnt = 0;
  int q2[$], t2[$];
  int b0, b1, bt, bs, c0;

  contador_periodos_multicanal #(
    .NUM_CANAIS(4), .CICLOS_POR_TICK(10), .LARGURA(16), .TIMEOUT_TICKS(50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sinal_in(sinal_in), .borda_descida(borda_descida),
    .modo_continuo(modo_continuo), .start(start), .canal_mask(canal_mask), .stop(stop),
    .ready(ready), .done(done), .timeout(timeout), .valido(valido), .periodo(periodo)
  );

  contador_periodos_multicanal #(
    .NUM_CANAIS(1), .CICLOS_POR_TICK(10), .LARGURA(4), .TIMEOUT_TICKS(0)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .sinal_in(sinal_in[0]), .borda_descida(borda_descida[0]),
    .modo_continuo(modo_continuo), .start(start), .canal_mask(canal_mask[0]), .stop(stop),
    .ready(s_ready), .done(s_done), .timeout(s_timeout), .valido(s_valido), .periodo(s_periodo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (done[i]) done_cnt[i]++;
      if (timeout[i]) begin
        to_cnt[i]++;
        to_t = cyc;
      end
    end
    if (done[2]) begin
      q2.push_back(int'(periodo[47:32]));
      t2.push_back(cyc);
    end
    if (s_done[0]) sd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [3:0] m, input logic cont);
    canal_mask = m;
    modo_continuo = cont;
    start = 1'b1;
    step(1);
    start = 1'b0;
    canal_mask = '0;
  endtask

  task automatic pulse(input logic [3:0] m);
    sinal_in = sinal_in | m;
    step(1);
    sinal_in = sinal_in & ~m;
  endtask

  task automatic wait_done(input int ch, input int budget, input logic [15:0] exp, input string tag);
    int n = 0;
    logic hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk);
      hit = done[ch];
      n++;
    end
    chk({tag, " done seen"}, 32'(hit), 32'd1);
    chk({tag, " periodo"}, 32'(periodo[ch*16 +: 16]), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b0;
    sinal_in = '0;
    borda_descida = '0;
    canal_mask = '0;
    modo_continuo = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    #2;
    chk("reset ready", 32'(ready), 1);
    chk("reset done", 32'(done), 0);
    chk("reset timeout", 32'(timeout), 0);
    chk("reset valido", 32'(valido), 0);
    chk("reset periodo lo", periodo[31:0], 0);
    chk("reset periodo hi", periodo[63:32], 0);
    step(3);
    rst_n = 1'b1;
    step(3);

    b0 = done_cnt[0];
    arm(4'b0001, 1'b0);
    chk("single ready low", 32'(ready), 0);
    step(5);
    pulse(4'b0001);
    step(249);
    pulse(4'b0001);
    wait_done(0, 10, 16'd25, "single");
    step(5);
    chk("single one done", 32'(done_cnt[0] - b0), 1);
    chk("single valido", 32'(valido[0]), 1);
    chk("single ready back", 32'(ready), 1);

    borda_descida = 4'b0010;
    sinal_in[1] = 1'b1;
    step(5);
    arm(4'b0010, 1'b0);
    step(3);
    sinal_in[1] = 1'b0;
    step(50);
    sinal_in[1] = 1'b1;
    step(59);
    sinal_in[1] = 1'b0;
    wait_done(1, 10, 16'd10, "falling");
    step(3);
    borda_descida = '0;
    chk("falling ready", 32'(ready), 1);

    b0 = done_cnt[0];
    b1 = done_cnt[1];
    q2.delete();
    t2.delete();
    arm(4'b1111, 1'b1);
    step(3);
    pulse(4'b0101);
    step(49);
    pulse(4'b0001);
    step(49);
    pulse(4'b0101);
    step(199);
    pulse(4'b0101);
    step(299);
    pulse(4'b0100);
    step(10);
    chk("cont ch2 count", 32'(q2.size()), 3);
    chk("cont ch2 p0", (q2.size() > 0) ? 32'(q2[0]) : 32'hFFFF, 10);
    chk("cont ch2 p1", (q2.size() > 1) ? 32'(q2[1]) : 32'hFFFF, 20);
    chk("cont ch2 p2", (q2.size() > 2) ? 32'(q2[2]) : 32'hFFFF, 30);
    chk("cont ch2 gap1", (t2.size() > 1) ? 32'(t2[1] - t2[0]) : 32'hFFFF, 200);
    chk("cont ch2 gap2", (t2.size() > 2) ? 32'(t2[2] - t2[1]) : 32'hFFFF, 300);
    chk("cont ch0 count", 32'(done_cnt[0] - b0), 3);
    chk("cont ch0 periodo", 32'(periodo[15:0]), 20);
    chk("cont ch1 no done", 32'(done_cnt[1] - b1), 0);
    chk("cont ch3 valido", 32'(valido[3]), 0);
    chk("cont busy", 32'(ready), 0);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("cont stop ready", 32'(ready), 1);
    chk("cont ch2 kept", 32'(periodo[47:32]), 30);

    bs = sd_cnt;
    arm(4'b0001, 1'b0);
    step(3);
    pulse(4'b0001);
    step(299);
    pulse(4'b0001);
    wait_done(0, 10, 16'd30, "sat wide");
    chk("sat narrow periodo", 32'(s_periodo), 15);
    step(2);
    chk("sat narrow done", 32'(sd_cnt - bs), 1);

    b0 = done_cnt[0];
    arm(4'b0001, 1'b0);
    step(3);
    pulse(4'b0001);
    step(100);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("stop ready", 32'(ready), 1);
    pulse(4'b0001);
    step(20);
    chk("stop no done", 32'(done_cnt[0] - b0), 0);
    chk("stop kept", 32'(periodo[15:0]), 30);
    stop = 1'b1;
    start = 1'b1;
    canal_mask = 4'hF;
    step(1);
    stop = 1'b0;
    start = 1'b0;
    canal_mask = '0;
    chk("start+stop ready", 32'(ready), 1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("mask0 ready", 32'(ready), 1);

    b0 = done_cnt[0];
    bt = to_cnt[0];
    arm(4'b0001, 1'b0);
    step(3);
    c0 = cyc;
    pulse(4'b0001);
    step(520);
    chk("timeout count", 32'(to_cnt[0] - bt), 1);
    chk("timeout latency", 32'(to_t - c0), 503);
    chk("timeout no done", 32'(done_cnt[0] - b0), 0);
    chk("timeout kept", 32'(periodo[15:0]), 30);
    chk("timeout ready", 32'(ready), 1);

    bt = to_cnt[0];
    arm(4'b0001, 1'b0);
    step(3);
    pulse(4'b0001);
    step(499);
    pulse(4'b0001);
    wait_done(0, 10, 16'd50, "collide");
    step(2);
    chk("collide no timeout", 32'(to_cnt[0] - bt), 0);
    chk("collide ready", 32'(ready), 1);

    arm(4'b0101, 1'b1);
    step(3);
    pulse(4'b0101);
    step(40);
    rst_n = 1'b0;
    #1;
    chk("rst mid ready", 32'(ready), 1);
    chk("rst mid valido", 32'(valido), 0);
    chk("rst mid periodo lo", periodo[31:0], 0);
    chk("rst mid periodo hi", periodo[63:32], 0);
    chk("rst mid done", 32'(done), 0);
    chk("rst mid narrow", 32'(s_periodo), 0);
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("rst release ready", 32'(ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
